// File: rtl/ikaopll_acc_mixer.sv
// rtl/ikaopll_acc_mixer.sv - time-multiplexed scaled accumulating mixer with one shared multiplier
// Per-channel hold/pend slots are scanned round-robin into a saturating accumulator, dumped once per frame.
module ikaopll_acc_mixer #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 10,
    parameter int VOL_W  = 5,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST,
    input  logic                     i_CEN_n,
    input  logic [NUM_CH-1:0]        i_VALID,
    input  logic [NUM_CH*IN_W-1:0]   i_SAMPLE,
    input  logic [NUM_CH*VOL_W-1:0]  i_VOL,
    input  logic                     i_FRAME,
    input  logic                     i_CLR_ERR,
    output logic                     o_STRB,
    output logic signed [OUT_W-1:0]  o_SAMPLE,
    output logic                     o_CLIP,
    output logic [NUM_CH-1:0]        o_OVF,
    output logic                     o_FRAME_MISS,
    output logic                     o_BUSY
);
    localparam int PROD_W = IN_W + VOL_W;
    localparam int PTR_W  = $clog2(NUM_CH);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DUMP} state_t;

    state_t                   state_q;
    logic [PTR_W-1:0]         ptr_q, ptr_d, cnt_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IN_W-1:0]          hold_q [NUM_CH];
    logic [NUM_CH-1:0]        pend_q;
    logic [NUM_CH-1:0]        ovf_q;
    logic                     strb_q, clip_q, miss_q;
    logic signed [OUT_W-1:0]  sample_q;

    logic                     scan_en, pend_sel, consume;
    logic signed [IN_W-1:0]   hold_sel;
    logic signed [VOL_W-1:0]  vol_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  acc_sh;
    logic                     dump_clip;
    logic signed [OUT_W-1:0]  dump_val;

    always_comb begin
        hold_sel = '0;
        vol_sel  = '0;
        pend_sel = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                hold_sel = hold_q[k];
                vol_sel  = i_VOL[k*VOL_W +: VOL_W];
                pend_sel = pend_q[k];
            end
        end
    end

    assign scan_en  = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign consume  = scan_en && pend_sel;
    assign prod     = PROD_W'(hold_sel) * PROD_W'(vol_sel);
    assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
    // Overflow shows up as disagreement between the guard bit and the ACC_W sign bit.
    assign acc_d    = (sum_wide[ACC_W] != sum_wide[ACC_W-1])
                    ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                    : sum_wide[ACC_W-1:0];
    assign ptr_d    = (ptr_q == PTR_W'(NUM_CH-1)) ? '0 : ptr_q + 1'b1;

    assign acc_sh    = acc_q >>> SHIFT;
    assign dump_clip = (acc_sh > OUT_MAX) || (acc_sh < OUT_MIN);
    assign dump_val  = dump_clip ? (acc_sh[ACC_W-1] ? OUT_MIN[OUT_W-1:0] : OUT_MAX[OUT_W-1:0])
                                 : acc_sh[OUT_W-1:0];

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= '0;
            strb_q   <= 1'b0;
            clip_q   <= 1'b0;
            miss_q   <= 1'b0;
            sample_q <= '0;
            for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
        end else begin
            // The strobe is a single master-clock pulse regardless of the clock enable.
            strb_q <= 1'b0;
            if (!i_CEN_n) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (i_VALID[k]) begin
                        hold_q[k] <= i_SAMPLE[k*IN_W +: IN_W];
                        pend_q[k] <= 1'b1;
                    end else if (consume && ptr_q == PTR_W'(k)) begin
                        pend_q[k] <= 1'b0;
                    end
                    if (i_VALID[k] && pend_q[k] && !(consume && ptr_q == PTR_W'(k)))
                        ovf_q[k] <= 1'b1;
                    else if (i_CLR_ERR)
                        ovf_q[k] <= 1'b0;
                end

                if (i_FRAME && state_q != ST_IDLE)
                    miss_q <= 1'b1;
                else if (i_CLR_ERR)
                    miss_q <= 1'b0;

                case (state_q)
                    ST_IDLE, ST_FLUSH: begin
                        if (pend_sel) acc_q <= acc_d;
                        ptr_q <= ptr_d;
                        if (state_q == ST_IDLE) begin
                            if (i_FRAME) begin
                                state_q <= ST_FLUSH;
                                cnt_q   <= '0;
                            end
                        end else if (cnt_q == PTR_W'(NUM_CH-1)) begin
                            state_q <= ST_DUMP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DUMP: begin
                        sample_q <= dump_val;
                        clip_q   <= dump_clip;
                        strb_q   <= 1'b1;
                        acc_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_STRB       = strb_q;
    assign o_SAMPLE     = sample_q;
    assign o_CLIP       = clip_q;
    assign o_OVF        = ovf_q;
    assign o_FRAME_MISS = miss_q;
    assign o_BUSY       = (state_q == ST_FLUSH) || (state_q == ST_DUMP);
endmodule
